// File: rtl/score_frame_rx.sv
// Sync-hunting byte-stream frame receiver feeding the segments decoder, with intra-frame timeout and stale watchdog.
// Optional XOR checksum byte after the payload: define PKT_CHECKSUM_EN.
module score_frame_rx #(
  parameter int unsigned DATA_BYTES   = 6,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned BYTE_TIMEOUT = 1000,
  parameter int unsigned STALE_CYCLES = 50_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_valid,
  output logic [DATA_BYTES*8-1:0] data,
  output logic                    data_valid,
  output logic                    frame_err,
  output logic                    stale
);

  localparam int unsigned DW = DATA_BYTES * 8;
  localparam int unsigned IW = $clog2(DATA_BYTES + 1);
  localparam int unsigned GW = $clog2(BYTE_TIMEOUT + 1);
  localparam int unsigned SW = $clog2(STALE_CYCLES + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BYTES - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(BYTE_TIMEOUT);
  localparam logic [GW-1:0] GAP_PRE   = GW'(BYTE_TIMEOUT - 1);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);
  localparam logic [SW-1:0] STALE_PRE = SW'(STALE_CYCLES - 1);

`ifdef PKT_CHECKSUM_EN
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
`else
  typedef enum logic [1:0] {HUNT, PAYLOAD} state_t;
`endif

  state_t        state;
  logic [IW-1:0] idx;
  logic [GW-1:0] gap;
  logic [SW-1:0] stale_cnt;
  logic [DW-1:0] shadow;
  logic [DW-1:0] shadow_next;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]    xsum;
`endif

  // Shadow with the current byte merged in, so the no-checksum build can commit on the last payload byte.
  always_comb begin
    shadow_next = shadow;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (idx == IW'(i)) shadow_next[(DATA_BYTES-1-i)*8 +: 8] = rx_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      idx        <= '0;
      gap        <= '0;
      stale_cnt  <= '0;
      shadow     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      stale      <= 1'b1;
`ifdef PKT_CHECKSUM_EN
      xsum       <= '0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      // Watchdog saturates; a commit below overrides both assignments.
      if (stale_cnt != STALE_MAX) stale_cnt <= stale_cnt + SW'(1);
      if (stale_cnt == STALE_PRE) stale <= 1'b1;

      // Gap counter only runs mid-frame; an arriving byte always beats the timeout.
      if (state != HUNT) begin
        if (rx_valid) begin
          gap <= '0;
        end else if (gap == GAP_PRE) begin
          gap       <= GAP_MAX;
          frame_err <= 1'b1;
          state     <= HUNT;
          idx       <= '0;
        end else begin
          gap <= gap + GW'(1);
        end
      end

      case (state)
        HUNT: begin
          if (rx_valid && rx_byte == SYNC_BYTE) begin
            state <= PAYLOAD;
            idx   <= '0;
            gap   <= '0;
`ifdef PKT_CHECKSUM_EN
            xsum  <= '0;
`endif
          end
        end

        PAYLOAD: begin
          if (rx_valid) begin
            shadow <= shadow_next;
            idx    <= idx + IW'(1);
`ifdef PKT_CHECKSUM_EN
            xsum   <= xsum ^ rx_byte;
            if (idx == LAST_IDX) state <= CHECK;
`else
            if (idx == LAST_IDX) begin
              data       <= shadow_next;
              data_valid <= 1'b1;
              stale_cnt  <= '0;
              stale      <= 1'b0;
              state      <= HUNT;
              idx        <= '0;
            end
`endif
          end
        end

`ifdef PKT_CHECKSUM_EN
        CHECK: begin
          if (rx_valid) begin
            state <= HUNT;
            idx   <= '0;
            if (rx_byte == xsum) begin
              data       <= shadow;
              data_valid <= 1'b1;
              stale_cnt  <= '0;
              stale      <= 1'b0;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
`endif

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_score_frame_rx.sv
// Directed bench for score_frame_rx; frames carry a checksum byte when PKT_CHECKSUM_EN is defined.
module tb_score_frame_rx;

  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned STALE   = 100;
`ifdef PKT_CHECKSUM_EN
  localparam int FINAL_IDX = 6;
`else
  localparam int FINAL_IDX = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        rx_valid = 1'b0;
  logic [47:0] data;
  logic        data_valid;
  logic        frame_err;
  logic        stale;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [47:0] exp_data;

  score_frame_rx #(
    .DATA_BYTES  (6),
    .SYNC_BYTE   (8'hA5),
    .BYTE_TIMEOUT(TIMEOUT),
    .STALE_CYCLES(STALE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .stale     (stale)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge, after the byte has been sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] p, input logic [7:0] ck_flip);
    logic [7:0] x;
    logic [7:0] b;
    x = '0;
    send_byte(8'hA5);
    for (int i = 0; i < 6; i++) begin
      b = p[47-8*i -: 8];
      x = x ^ b;
      send_byte(b);
      if (i < FINAL_IDX) check_eq("dv_early", {63'd0, data_valid}, 64'd0);
    end
`ifdef PKT_CHECKSUM_EN
    send_byte(x ^ ck_flip);
`endif
  endtask

  task automatic expect_commit(input string tag, input logic [47:0] p);
    check_eq({tag, "_data"}, {16'd0, data}, {16'd0, p});
    check_eq({tag, "_dv"}, {63'd0, data_valid}, 64'd1);
    check_eq({tag, "_fe"}, {63'd0, frame_err}, 64'd0);
    check_eq({tag, "_stale"}, {63'd0, stale}, 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_data", {16'd0, data}, 64'd0);
    check_eq("rst_dv", {63'd0, data_valid}, 64'd0);
    check_eq("rst_fe", {63'd0, frame_err}, 64'd0);
    check_eq("rst_stale", {63'd0, stale}, 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Good frame (checksum 07), then a second frame back-to-back
    check_eq("stale_before", {63'd0, stale}, 64'd1);
    send_frame(48'h010203040506, 8'h00);
    expect_commit("good1", 48'h010203040506);
    send_frame(48'hDEADBEEF0102, 8'h00);
    expect_commit("b2b", 48'hDEADBEEF0102);
    exp_data = 48'hDEADBEEF0102;
    @(negedge clk);
    check_eq("dv_one_cycle", {63'd0, data_valid}, 64'd0);

`ifdef PKT_CHECKSUM_EN
    // 11..66 XOR to 77; flip gives checksum 00
    send_frame(48'h112233445566, 8'h77);
    check_eq("badck_fe", {63'd0, frame_err}, 64'd1);
    check_eq("badck_dv", {63'd0, data_valid}, 64'd0);
    check_eq("badck_data", {16'd0, data}, {16'd0, exp_data});
    @(negedge clk);
    check_eq("badck_fe_off", {63'd0, frame_err}, 64'd0);
`endif

    // Garbage before sync, sync values inside payload
    send_byte(8'h00);
    send_byte(8'hFF);
    check_eq("garbage_dv", {63'd0, data_valid}, 64'd0);
    send_frame(48'hA5A5A5A5A5A5, 8'h00);
    expect_commit("sync_in_pl", 48'hA5A5A5A5A5A5);
    exp_data = 48'hA5A5A5A5A5A5;

    // Intra-frame timeout
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (TIMEOUT - 1) @(negedge clk);
    check_eq("to_early", {63'd0, frame_err}, 64'd0);
    @(negedge clk);
    check_eq("to_fe", {63'd0, frame_err}, 64'd1);
    check_eq("to_data", {16'd0, data}, {16'd0, exp_data});
    check_eq("to_dv", {63'd0, data_valid}, 64'd0);
    @(negedge clk);
    check_eq("to_fe_off", {63'd0, frame_err}, 64'd0);
    check_eq("to_stale", {63'd0, stale}, 64'd1);
    send_frame(48'h0A0B0C0D0E0F, 8'h00);
    expect_commit("after_to", 48'h0A0B0C0D0E0F);

    // Stale watchdog: asserts on the 100th idle cycle after commit
    repeat (STALE - 1) @(negedge clk);
    check_eq("stale_99", {63'd0, stale}, 64'd0);
    @(negedge clk);
    check_eq("stale_100", {63'd0, stale}, 64'd1);
    send_frame(48'h665544332211, 8'h00);
    expect_commit("stale_clr", 48'h665544332211);

    // Reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h02);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_data", {16'd0, data}, 64'd0);
    check_eq("mrst_stale", {63'd0, stale}, 64'd1);
    check_eq("mrst_dv", {63'd0, data_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(48'h123456789ABC, 8'h00);
    expect_commit("post_rst", 48'h123456789ABC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
